finish_sequencer: RTL and testbench

FINISH_SEQUENCER -- requirements
Module: finish_sequencer

---
 rtl/finish_seq_pkg.sv | 14 +
 rtl/finish_sequencer_rr_arbiter.sv | 25 ++
 rtl/finish_sequencer.sv | 124 ++++++++++++
 tb/tb_finish_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/finish_seq_pkg.sv
// finish_seq_pkg: shared FSM state type and width helpers for the finish sequencer.
package finish_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FINISH, DONE} state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/finish_sequencer_rr_arbiter.sv
// rr_arbiter: round-robin pick of one eligible unit, searching upward from ptr and wrapping.
module rr_arbiter
    import finish_seq_pkg::*;
#(
    parameter int NUM_UNITS = 2
) (
    input  logic [NUM_UNITS-1:0]          eligible,
    input  logic [idx_w(NUM_UNITS)-1:0]   ptr,
    output logic [NUM_UNITS-1:0]          grant,
    output logic [idx_w(NUM_UNITS)-1:0]   grant_idx
);

    localparam int IW = idx_w(NUM_UNITS);

    // lowest eligible index at or above ptr wins; otherwise the lowest one below it
    always_comb begin
        grant_idx = '0;
        for (int j = NUM_UNITS - 1; j >= 0; j--)
            if (eligible[j] && j < int'(ptr)) grant_idx = IW'(j);
        for (int j = NUM_UNITS - 1; j >= 0; j--)
            if (eligible[j] && j >= int'(ptr)) grant_idx = IW'(j);
        grant = (|eligible) ? NUM_UNITS'(1) << grant_idx : '0;
    end

endmodule

// File: rtl/finish_sequencer.sv
// finish_sequencer: acknowledges one completion request per cycle until all units are done or
// the run times out, then pulses finish. Define FINISH_SIM_STOP_EN to end simulation on finish.
module finish_sequencer
    import finish_seq_pkg::*;
#(
    parameter int NUM_UNITS = 2,
    parameter int TIMEOUT_W = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [TIMEOUT_W-1:0]          timeout_limit,
    input  logic [NUM_UNITS-1:0]          unit_req,
    output logic [NUM_UNITS-1:0]          unit_ack,
    output logic                          busy,
    output logic [cnt_w(NUM_UNITS)-1:0]   done_count,
    output logic                          finish,
    output logic                          pass,
    output logic                          timeout_flag
);

    localparam int CW = cnt_w(NUM_UNITS);
    localparam int IW = idx_w(NUM_UNITS);

    state_t               state_q;
    logic [NUM_UNITS-1:0] mask_q, mask_d, ack_q, eligible, grant;
    logic [CW-1:0]        count_q, count_d;
    logic [TIMEOUT_W-1:0] cyc_q, cyc_d, limit_q;
    logic [IW-1:0]        ptr_q, ptr_d, grant_idx;
    logic                 busy_q, fin_q, pass_q, to_q, expire;

    assign eligible = unit_req & ~mask_q;

    rr_arbiter #(.NUM_UNITS(NUM_UNITS)) u_arb (
        .eligible  (eligible),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // next values for a RUN cycle; a timeout only counts when this cycle's grant is not the last one
    always_comb begin
        mask_d  = mask_q | grant;
        count_d = count_q + CW'(|grant);
        cyc_d   = &cyc_q ? cyc_q : cyc_q + 1'b1;
        ptr_d   = ~|grant ? ptr_q : grant_idx == IW'(NUM_UNITS - 1) ? '0 : grant_idx + 1'b1;
        expire  = limit_q != '0 && cyc_d == limit_q && count_d != CW'(NUM_UNITS);
    end

    // run FSM with registered outputs; FINISH is entered one cycle after the last ack so it carries none
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            ack_q   <= '0;
            count_q <= '0;
            cyc_q   <= '0;
            limit_q <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            pass_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            ack_q <= '0;
            fin_q <= 1'b0;
            case (state_q)
                IDLE, DONE: if (start) begin
                    state_q <= RUN;
                    busy_q  <= 1'b1;
                    mask_q  <= '0;
                    count_q <= '0;
                    cyc_q   <= '0;
                    limit_q <= timeout_limit;
                    pass_q  <= 1'b0;
                    to_q    <= 1'b0;
                end
                RUN: begin
                    cyc_q <= cyc_d;
                    if (count_q == CW'(NUM_UNITS)) begin
                        state_q <= FINISH;
                        fin_q   <= 1'b1;
                        pass_q  <= 1'b1;
                    end else if (expire) begin
                        state_q <= FINISH;
                        fin_q   <= 1'b1;
                        to_q    <= 1'b1;
                    end else begin
                        ack_q   <= grant;
                        mask_q  <= mask_d;
                        count_q <= count_d;
                        ptr_q   <= ptr_d;
                    end
                end
                FINISH: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign unit_ack     = ack_q;
    assign busy         = busy_q;
    assign done_count   = count_q;
    assign finish       = fin_q;
    assign pass         = pass_q;
    assign timeout_flag = to_q;

`ifdef FINISH_SIM_STOP_EN
`ifndef SYNTHESIS
    // report the verdict and stop the simulation on the finish pulse
    always_ff @(posedge clock) begin
        if (fin_q) begin
            $display("finish_sequencer: pass=%0b timeout_flag=%0b", pass_q, to_q);
            $finish;
        end
    end
`endif
`else
`endif

endmodule

// File: tb/tb_finish_sequencer.sv
// tb_finish_sequencer: random and directed runs scored against a run-level reference model.
module tb_finish_sequencer;

    localparam int N  = 3;
    localparam int TW = 4;
    localparam int CW = 2;

    logic          clock = 1'b0, reset = 1'b0, start = 1'b0;
    logic [TW-1:0] timeout_limit = '0;
    logic [N-1:0]  unit_req = '0, unit_ack;
    logic [CW-1:0] done_count;
    logic          busy, finish, pass, timeout_flag;

    always #5 clock = ~clock;

    finish_sequencer #(.NUM_UNITS(N), .TIMEOUT_W(TW)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .timeout_limit(timeout_limit),
        .unit_req     (unit_req),
        .unit_ack     (unit_ack),
        .busy         (busy),
        .done_count   (done_count),
        .finish       (finish),
        .pass         (pass),
        .timeout_flag (timeout_flag)
    );

    typedef struct {
        int         cyc;
        logic [N-1:0] ack;
        logic       fin;
        logic       ps;
        logic       to;
        int         cnt;
    } ev_t;

    ev_t q[$];
    ev_t e;
    int  checks = 0, errors = 0, cyc_n = 0;

    bit         running = 0, settle = 0;
    bit [N-1:0] acked = '0;
    int         n = 0, rcyc = 0, lim = 0, ptr = 0;
    int         m_pass = 0, m_to = 0, m_cnt = 0;

    always @(posedge clock) cyc_n++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    function automatic void push_ev(input logic [N-1:0] ack, input logic fin, input logic ps,
                                    input logic to, input int cnt);
        ev_t x;
        x.cyc = cyc_n + 1; x.ack = ack; x.fin = fin; x.ps = ps; x.to = to; x.cnt = cnt;
        q.push_back(x);
        if (fin) begin m_pass = int'(ps); m_to = int'(to); m_cnt = cnt; end
    endfunction

    // scoreboard monitor: every ack or finish the DUT shows must match the next predicted event
    always @(negedge clock) begin
        if ((|unit_ack) || finish) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: ack=%b finish=%b with nothing expected (cycle %0d)",
                         unit_ack, finish, cyc_n);
            end else begin
                e = q.pop_front();
                check("event_cycle", cyc_n, e.cyc);
                check("unit_ack", unit_ack, e.ack);
                check("finish", finish, e.fin);
                check("done_count", done_count, e.cnt);
                if (e.fin) begin
                    check("pass", pass, e.ps);
                    check("timeout_flag", timeout_flag, e.to);
                    check("busy_in_finish", busy, 1);
                end
            end
        end
    end

    // drive one edge's inputs and predict what that edge produces
    task automatic step(input logic s, input logic [TW-1:0] lim_i, input logic [N-1:0] req,
                        input logic rst_n);
        int k, j;
        start = s; timeout_limit = lim_i; unit_req = req; reset = rst_n;
        if (!rst_n) begin
            running = 0; settle = 0; ptr = 0;
        end else if (settle) begin
            settle = 0;
        end else if (!running) begin
            if (s) begin running = 1; acked = '0; n = 0; rcyc = 0; lim = int'(lim_i); end
        end else begin
            rcyc = rcyc < (1 << TW) - 1 ? rcyc + 1 : rcyc;
            if (n == N) begin
                push_ev('0, 1, 1, 0, n);
                running = 0; settle = 1;
            end else begin
                k = -1;
                for (int i = 0; i < N; i++) begin
                    j = (ptr + i) % N;
                    if (k < 0 && req[j] && !acked[j]) k = j;
                end
                if (n + (k >= 0 ? 1 : 0) < N && lim != 0 && rcyc == lim) begin
                    push_ev('0, 1, 0, 1, n);
                    running = 0; settle = 1;
                end else if (k >= 0) begin
                    acked[k] = 1'b1; n++; ptr = (k + 1) % N;
                    push_ev(N'(1) << k, 0, 0, 0, n);
                end
            end
        end
        @(posedge clock);
        #2;
    endtask

    task automatic run_const(input logic [TW-1:0] l, input logic [N-1:0] req, input int cycles);
        step(1'b1, l, '0, 1'b1);
        for (int i = 0; i < cycles; i++) step(1'b0, '0, req, 1'b1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ack"}, unit_ack, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_finish"}, finish, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_timeout"}, timeout_flag, 0);
        check({tag, "_count"}, done_count, 0);
    endtask

    task automatic check_done(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pass"}, pass, m_pass);
        check({tag, "_timeout"}, timeout_flag, m_to);
        check({tag, "_count"}, done_count, m_cnt);
    endtask

    initial begin
        logic [N-1:0] rq;
        logic [TW-1:0] rl;
        step(1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        check_idle_outputs("reset");

        run_const(4'd0, 3'b111, 8);
        check_done("all_done");
        check("all_done_pass", pass, 1);

        run_const(4'd5, 3'b000, 8);
        check_done("timeout5");
        check("timeout5_flag", timeout_flag, 1);

        step(1'b1, 4'd0, '0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 3'b001, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 3'b011, 1'b1);
        check("sticky_count", done_count, 2);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 3'b111, 1'b1);
        check_done("sticky");

        run_const(4'd3, 3'b111, 6);
        check_done("grant_wins");
        check("grant_wins_pass", pass, 1);

        step(1'b1, 4'd0, '0, 1'b1);
        step(1'b0, '0, 3'b001, 1'b1);
        step(1'b0, '0, 3'b001, 1'b1);
        check("pre_reset_count", done_count, 1);
        step(1'b0, '0, 3'b110, 1'b0);
        check_idle_outputs("midrun_reset");
        run_const(4'd0, 3'b111, 8);
        check_done("after_reset");

        rq = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int u = 0; u < N; u++) begin
                if (!rq[u]) rq[u] = $urandom_range(0, 4) == 0;
                else if (acked[u] && $urandom_range(0, 1) == 1) rq[u] = 1'b0;
            end
            case ($urandom_range(0, 3))
                0: rl = '0;
                1: rl = TW'($urandom_range(1, 4));
                default: rl = TW'($urandom_range(0, 15));
            endcase
            step($urandom_range(0, 3) == 0, rl, rq, $urandom_range(0, 250) != 0);
        end
        for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b1);
        check("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
